// File: rtl/gpr_wb_arbiter.sv
// ============================================================================
// Module  : gpr_wb_arbiter
// Brief   : Three-way register-file write-back arbiter with a registered
//           write port. Define GPR_WB_RR_EN for round-robin arbitration;
//           otherwise priority is fixed at 0 > 1 > 2.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module gpr_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        req_valid,
  output logic [2:0]        req_ready,
  input  logic [ADDR_W-1:0] req_addr_0,
  input  logic [ADDR_W-1:0] req_addr_1,
  input  logic [ADDR_W-1:0] req_addr_2,
  input  logic [DATA_W-1:0] req_data_0,
  input  logic [DATA_W-1:0] req_data_1,
  input  logic [DATA_W-1:0] req_data_2,
  input  logic              hold,
  output logic              gpr_we,
  output logic [ADDR_W-1:0] gpr_wr_addr,
  output logic [DATA_W-1:0] gpr_wr_data,
  output logic [1:0]        grant_id
);

  localparam logic [1:0] c_idle_id = 2'd3;

  function automatic logic [1:0] next_idx(input logic [1:0] idx);
    return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

  logic [1:0]        w_c0, w_c1, w_c2;
  logic              w_found;
  logic [1:0]        w_gidx;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_data;

  logic              r_gpr_we;
  logic [ADDR_W-1:0] r_gpr_wr_addr;
  logic [DATA_W-1:0] r_gpr_wr_data;
  logic [1:0]        r_grant_id;

`ifdef GPR_WB_RR_EN
  logic [1:0] r_rr_ptr;

  // Search begins one past the last granted requester.
  assign w_c0 = next_idx(r_rr_ptr);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr <= 2'd2;
    end else if (w_found) begin
      r_rr_ptr <= w_gidx;
    end
  end
`else
  assign w_c0 = 2'd0;
`endif

  assign w_c1 = next_idx(w_c0);
  assign w_c2 = next_idx(w_c1);

  always_comb begin
    w_found = 1'b0;
    w_gidx  = 2'd0;
    if (!rst && !hold) begin
      if (req_valid[w_c0]) begin
        w_found = 1'b1;
        w_gidx  = w_c0;
      end else if (req_valid[w_c1]) begin
        w_found = 1'b1;
        w_gidx  = w_c1;
      end else if (req_valid[w_c2]) begin
        w_found = 1'b1;
        w_gidx  = w_c2;
      end
    end
  end

  assign req_ready = w_found ? (3'b001 << w_gidx) : 3'b000;

  always_comb begin
    w_sel_addr = req_addr_0;
    w_sel_data = req_data_0;
    case (w_gidx)
      2'd1: begin
        w_sel_addr = req_addr_1;
        w_sel_data = req_data_1;
      end
      2'd2: begin
        w_sel_addr = req_addr_2;
        w_sel_data = req_data_2;
      end
      default: begin
        w_sel_addr = req_addr_0;
        w_sel_data = req_data_0;
      end
    endcase
  end

  // Writes to register 0 are consumed but never reach the register file.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_gpr_we      <= 1'b0;
      r_gpr_wr_addr <= '0;
      r_gpr_wr_data <= '0;
      r_grant_id    <= c_idle_id;
    end else begin
      r_gpr_we <= w_found && (w_sel_addr != '0);
      if (w_found) begin
        r_gpr_wr_addr <= w_sel_addr;
        r_gpr_wr_data <= w_sel_data;
        r_grant_id    <= w_gidx;
      end else begin
        r_grant_id    <= c_idle_id;
      end
    end
  end

  assign gpr_we      = r_gpr_we;
  assign gpr_wr_addr = r_gpr_wr_addr;
  assign gpr_wr_data = r_gpr_wr_data;
  assign grant_id    = r_grant_id;

endmodule

`default_nettype wire

// File: tb/tb_gpr_wb_arbiter.sv
// ============================================================================
// Module  : tb_gpr_wb_arbiter
// Brief   : Scoreboard bench for gpr_wb_arbiter; directed scenarios followed
//           by random traffic against a queue-based reference model.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_gpr_wb_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [2:0]    req_valid = 3'b000;
  logic [2:0]    req_ready;
  logic [AW-1:0] a0 = '0, a1 = '0, a2 = '0;
  logic [DW-1:0] d0 = '0, d1 = '0, d2 = '0;
  logic          hold = 1'b0;
  logic          gpr_we;
  logic [AW-1:0] gpr_wr_addr;
  logic [DW-1:0] gpr_wr_data;
  logic [1:0]    grant_id;

  always #5 clk = ~clk;

  gpr_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr_0(a0), .req_addr_1(a1), .req_addr_2(a2),
    .req_data_0(d0), .req_data_1(d1), .req_data_2(d2),
    .hold(hold), .gpr_we(gpr_we), .gpr_wr_addr(gpr_wr_addr),
    .gpr_wr_data(gpr_wr_data), .grant_id(grant_id)
  );

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [1:0]    gid;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference state: last granted index and the held write-port contents.
  int            m_last = 2;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_data = '0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
  endtask

  function automatic logic [AW-1:0] addr_of(input int i);
    return (i == 0) ? a0 : (i == 1) ? a1 : a2;
  endfunction

  function automatic logic [DW-1:0] data_of(input int i);
    return (i == 0) ? d0 : (i == 1) ? d1 : d2;
  endfunction

  // Decide this cycle's winner from the rules, check ready, queue the result.
  task automatic model_step();
    int   g;
    int   c;
    logic [2:0] exp_rdy;
    exp_t e;
    g = -1;
    if (!rst && !hold) begin
      for (int k = 0; k < 3; k++) begin
`ifdef GPR_WB_RR_EN
        c = (m_last + 1 + k) % 3;
`else
        c = k;
`endif
        if (g < 0 && req_valid[c]) g = c;
      end
    end
    exp_rdy = (g < 0) ? 3'b000 : 3'(1 << g);
    chk("req_ready", DW'(req_ready), DW'(exp_rdy));
    if (rst) begin
      m_last = 2;
      m_addr = '0;
      m_data = '0;
      e = '{we: 1'b0, addr: '0, data: '0, gid: 2'd3};
    end else if (g >= 0) begin
      m_last = g;
      m_addr = addr_of(g);
      m_data = data_of(g);
      e = '{we: (m_addr != 0), addr: m_addr, data: m_data, gid: 2'(g)};
    end else begin
      e = '{we: 1'b0, addr: m_addr, data: m_data, gid: 2'd3};
    end
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic r, input logic h, input logic [2:0] v,
                       input logic [AW-1:0] x0, input logic [AW-1:0] x1, input logic [AW-1:0] x2,
                       input logic [DW-1:0] y0, input logic [DW-1:0] y1, input logic [DW-1:0] y2);
    @(negedge clk);
    rst = r; hold = h; req_valid = v;
    a0 = x0; a1 = x1; a2 = x2;
    d0 = y0; d1 = y1; d2 = y2;
    #1;
    model_step();
  endtask

  task automatic idle(input logic r);
    drive(r, 1'b0, 3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
  endtask

  // Monitor: the output stage presents a result every cycle.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("gpr_we",      DW'(gpr_we),      DW'(e.we));
      chk("gpr_wr_addr", DW'(gpr_wr_addr), DW'(e.addr));
      chk("gpr_wr_data", gpr_wr_data,      e.data);
      chk("grant_id",    DW'(grant_id),    DW'(e.gid));
    end
  end

  initial begin
    int budget;
    idle(1'b1);
    idle(1'b1);

    // Single ALU write.
    drive(1'b0, 1'b0, 3'b001, 5'd5, 5'd0, 5'd0, 32'hDEADBEEF, 32'h0, 32'h0);
    idle(1'b0);

    // All three requesting for six cycles straight after reset.
    idle(1'b1);
    repeat (6) drive(1'b0, 1'b0, 3'b111, 5'd10, 5'd11, 5'd12, 32'h100, 32'h101, 32'h102);
    idle(1'b0);

    // Write to register 0 from the load unit.
    drive(1'b0, 1'b0, 3'b010, 5'd0, 5'd0, 5'd0, 32'h0, 32'h1234, 32'h0);
    idle(1'b0);

    // Hold for three cycles, then release with requests still pending.
    repeat (3) drive(1'b0, 1'b1, 3'b101, 5'd3, 5'd0, 5'd4, 32'h33, 32'h0, 32'h44);
    drive(1'b0, 1'b0, 3'b101, 5'd3, 5'd0, 5'd4, 32'h33, 32'h0, 32'h44);
    idle(1'b0);

    // Transfer immediately followed by reset.
    drive(1'b0, 1'b0, 3'b001, 5'd9, 5'd0, 5'd0, 32'hCAFE, 32'h0, 32'h0);
    idle(1'b1);
    idle(1'b0);

    // Same destination from requesters 0 and 2 after reset.
    idle(1'b1);
    drive(1'b0, 1'b0, 3'b101, 5'd7, 5'd0, 5'd7, 32'hA, 32'h0, 32'hB);
    drive(1'b0, 1'b0, 3'b100, 5'd7, 5'd0, 5'd7, 32'hA, 32'h0, 32'hB);
    idle(1'b0);

    // Random traffic, including occasional reset and hold.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 4) == 0),
            3'($urandom_range(0, 7)),
            5'($urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 31)),
            5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
            $urandom, $urandom, $urandom);
    end
    idle(1'b0);
    idle(1'b0);

    budget = 10;
    while (exp_q.size() > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d pending expected 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
